mc_maindec: RTL and testbench
=============================

# mc_maindec

Multicycle main controller for the tinymips core: a Moore state machine that sequences each instruction through fetch, decode, execute, memory and writeback cycles. It drives the datapath's enables and mux selects from the instruction opcode. It is the multicycle counterpart of the single-cycle main decoder, extended with optional BNE/ORI support, a memory-ready wait handshake, a sticky illegal-opcode trap and a state debug port for the monitor. It sits in the controller beside the ALU decoder, which consumes `aluop`.

## Interface
- `MEM_WAIT`, default 1: 1 = FETCH/MEMRD/MEMWR wait for `mem_ready`; 0 = `mem_ready` ignored, treated as 1.
- `EXT_OPS`, default 1: 1 = BNE (000101) and ORI (001101) decoded; 0 = both are illegal.
- `clk` in 1: single clock, all state changes on rising edge.
- `reset` in 1: synchronous, active-high; next state FETCH.
- `op` in 6: instruction opcode (instr[31:26]), valid from DECODE onward.
- `mem_ready` in 1: memory access completes this cycle.
- `pcwrite` out 1: unconditional PC load.
- `branch`, `branchne` out 1: PC load if zero / if not zero.
- `irwrite` out 1: instruction register load.
- `memwrite`, `regwrite` out 1: write enables.
- `iord` out 1: 0 = PC addresses memory, 1 = ALUOut.
- `alusrca` out 1: 0 = PC, 1 = rs.
- `alusrcb` out 2: 00 rt, 01 const 4, 10 imm, 11 signimm<<2.
- `zeroext` out 1: immediate zero-extended (ORI).
- `pcsrc` out 2: 00 ALU result, 01 ALUOut, 10 jump target.
- `memtoreg`, `regdst` out 1: writeback mux selects.
- `aluop` out 2: 00 add, 01 sub, 10 funct, 11 or.
- `illegal` out 1: trap state active.
- `state_dbg` out 4: current state encoding.

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEX 6, RTWB 7, BEQEX 8, ADDIEX 9, IWB 10, JEX 11, BNEEX 12, ORIEX 13, TRAP 14; 15 unused, next state FETCH.
- Outputs are combinational from state (and `mem_ready`). Any output not listed below is 0 in that state.
- FETCH: alusrcb=01; irwrite=pcwrite=`mem_ready`. Stays until `mem_ready`, then DECODE.
- DECODE: alusrcb=11. Next state by `op`:
  - 100011 or 101011 -> MEMADR
  - 000000 -> RTEX
  - 000100 -> BEQEX
  - 001000 -> ADDIEX
  - 000010 -> JEX
  - 000101 -> BNEEX (EXT_OPS)
  - 001101 -> ORIEX (EXT_OPS)
  - anything else -> TRAP
- MEMADR: alusrca=1, alusrcb=10. Next MEMRD if op=100011, else MEMWR.
- MEMRD: iord=1. Stays until `mem_ready`, then MEMWB.
- MEMWB: memtoreg=1, regwrite=1 -> FETCH.
- MEMWR: iord=1, memwrite=1 held while waiting. Stays until `mem_ready`, then FETCH.
- RTEX: alusrca=1, aluop=10 -> RTWB.
- RTWB: regdst=1, regwrite=1 -> FETCH.
- BEQEX: alusrca=1, aluop=01, pcsrc=01, branch=1 -> FETCH.
- BNEEX: same as BEQEX but branchne=1, branch=0 -> FETCH.
- ADDIEX: alusrca=1, alusrcb=10 -> IWB.
- ORIEX: alusrca=1, alusrcb=10, aluop=11, zeroext=1 -> IWB.
- IWB: regwrite=1 -> FETCH.
- JEX: pcsrc=10, pcwrite=1 -> FETCH.
- TRAP: illegal=1, all enables 0. Sticky until reset.

## Timing
- Reset value: state FETCH, so state_dbg=0, alusrcb=01, irwrite=pcwrite=`mem_ready` (1 when MEM_WAIT=0), and every other output 0, illegal included.
- Reset has priority over all transitions. Asserted mid-instruction, the FSM is in FETCH on the next edge with no further writes.
- Cycles per instruction with `mem_ready` held 1: LW 5, SW 4, R-type 4, ADDI/ORI 4, BEQ/BNE 3, J 3.
- Each cycle `mem_ready` is low in FETCH, MEMRD or MEMWR adds one cycle.
- Write enables are never asserted in two consecutive states for the same instruction, except memwrite during MEMWR waits.
- `op` is sampled only in DECODE and MEMADR.

## Test plan
- Reset then LW (op=100011), mem_ready=1: state_dbg 0,1,2,3,4,0; regwrite=1 and memtoreg=1 only in cycle 5.
- SW with mem_ready low 2 cycles in MEMWR: memwrite=1 for 3 consecutive cycles, then state 0.
- MEM_WAIT=1, mem_ready=0 in FETCH for 3 cycles: state stays 0, irwrite=pcwrite=0; on mem_ready=1 both pulse, next state 1.
- EXT_OPS=1, BNE then ORI: BNEEX has branchne=1, pcsrc=01, aluop=01; ORIEX has aluop=11, zeroext=1, then IWB regwrite=1. With EXT_OPS=0, op=000101 -> state 14, illegal=1.
- Illegal op=111111: TRAP held for 10 cycles, all enables 0; reset returns state 0, illegal=0.
- Reset asserted in RTEX: next state 0, regwrite never asserted.

Source files
------------

// File: rtl/mc_maindec_if.sv
// Control bundle between the multicycle main decoder and the tinymips datapath.
// The controller takes the master side; the datapath or a bench takes the slave side.
interface mc_maindec_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       pcwrite;
  logic       branch;
  logic       branchne;
  logic       irwrite;
  logic       memwrite;
  logic       regwrite;
  logic       iord;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       zeroext;
  logic [1:0] pcsrc;
  logic       memtoreg;
  logic       regdst;
  logic [1:0] aluop;
  logic       illegal;
  logic [3:0] state_dbg;

  modport master (
    input  op, mem_ready,
    output pcwrite, branch, branchne, irwrite, memwrite, regwrite, iord,
           alusrca, alusrcb, zeroext, pcsrc, memtoreg, regdst, aluop,
           illegal, state_dbg
  );

  modport slave (
    output op, mem_ready,
    input  pcwrite, branch, branchne, irwrite, memwrite, regwrite, iord,
           alusrca, alusrcb, zeroext, pcsrc, memtoreg, regdst, aluop,
           illegal, state_dbg
  );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle Moore controller for tinymips: sequences fetch/decode/execute/memory/writeback
// and drives datapath enables and mux selects, with a sticky trap on illegal opcodes.
module mc_maindec #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit EXT_OPS  = 1'b1
) (
  input logic          clk,
  input logic          reset,
  mc_maindec_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB   = 4'd7,
    S_BEQEX  = 4'd8,  S_ADDIEX = 4'd9,  S_IWB    = 4'd10, S_JEX    = 4'd11,
    S_BNEEX  = 4'd12, S_ORIEX  = 4'd13, S_TRAP   = 4'd14, S_UNUSED = 4'd15
  } state_t;

  state_t state_r;
  state_t state_next_s;
  logic   ready_s;

  // Without memory wait support the handshake is treated as always complete.
  assign ready_s       = MEM_WAIT ? bus.mem_ready : 1'b1;
  assign bus.state_dbg = state_r;

  // State register; reset overrides every transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_FETCH:  state_next_s = ready_s ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.op)
          6'b100011, 6'b101011: state_next_s = S_MEMADR;
          6'b000000:            state_next_s = S_RTEX;
          6'b000100:            state_next_s = S_BEQEX;
          6'b001000:            state_next_s = S_ADDIEX;
          6'b000010:            state_next_s = S_JEX;
          6'b000101:            state_next_s = EXT_OPS ? S_BNEEX : S_TRAP;
          6'b001101:            state_next_s = EXT_OPS ? S_ORIEX : S_TRAP;
          default:              state_next_s = S_TRAP;
        endcase
      end
      S_MEMADR: state_next_s = (bus.op == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next_s = ready_s ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next_s = S_FETCH;
      S_MEMWR:  state_next_s = ready_s ? S_FETCH : S_MEMWR;
      S_RTEX:   state_next_s = S_RTWB;
      S_RTWB:   state_next_s = S_FETCH;
      S_BEQEX:  state_next_s = S_FETCH;
      S_BNEEX:  state_next_s = S_FETCH;
      S_ADDIEX: state_next_s = S_IWB;
      S_ORIEX:  state_next_s = S_IWB;
      S_IWB:    state_next_s = S_FETCH;
      S_JEX:    state_next_s = S_FETCH;
      S_TRAP:   state_next_s = S_TRAP;
      default:  state_next_s = S_FETCH;
    endcase
  end

  // Moore outputs; only FETCH also looks at the memory handshake.
  always_comb begin
    bus.pcwrite  = 1'b0;
    bus.branch   = 1'b0;
    bus.branchne = 1'b0;
    bus.irwrite  = 1'b0;
    bus.memwrite = 1'b0;
    bus.regwrite = 1'b0;
    bus.iord     = 1'b0;
    bus.alusrca  = 1'b0;
    bus.alusrcb  = 2'b00;
    bus.zeroext  = 1'b0;
    bus.pcsrc    = 2'b00;
    bus.memtoreg = 1'b0;
    bus.regdst   = 1'b0;
    bus.aluop    = 2'b00;
    bus.illegal  = 1'b0;
    case (state_r)
      S_FETCH: begin
        bus.alusrcb = 2'b01;
        bus.irwrite = ready_s;
        bus.pcwrite = ready_s;
      end
      S_DECODE: bus.alusrcb = 2'b11;
      S_MEMADR: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_MEMRD:  bus.iord = 1'b1;
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWR: begin
        bus.iord     = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_RTEX: begin
        bus.alusrca = 1'b1;
        bus.aluop   = 2'b10;
      end
      S_RTWB: begin
        bus.regdst   = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        bus.alusrca  = 1'b1;
        bus.aluop    = 2'b01;
        bus.pcsrc    = 2'b01;
        bus.branch   = (state_r == S_BEQEX);
        bus.branchne = (state_r == S_BNEEX);
      end
      S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
      end
      S_ORIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = 2'b10;
        bus.aluop   = 2'b11;
        bus.zeroext = 1'b1;
      end
      S_IWB:    bus.regwrite = 1'b1;
      S_JEX: begin
        bus.pcsrc   = 2'b10;
        bus.pcwrite = 1'b1;
      end
      S_TRAP:   bus.illegal = 1'b1;
      default:  bus.illegal = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Scoreboard bench for mc_maindec: one instance with default parameters and one with
// EXT_OPS=0, MEM_WAIT=0; directed cycles push expected state/controls, a monitor checks.
module tb_mc_maindec;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  mc_maindec_if ifa ();
  mc_maindec_if ifb ();

  mc_maindec #(.MEM_WAIT(1'b1), .EXT_OPS(1'b1)) dut_a (.clk(clk), .reset(rst_a), .bus(ifa));
  mc_maindec #(.MEM_WAIT(1'b0), .EXT_OPS(1'b0)) dut_b (.clk(clk), .reset(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  // Control vector order:
  // pcwrite branch branchne irwrite memwrite regwrite iord alusrca alusrcb zeroext pcsrc memtoreg regdst aluop illegal
  function automatic logic [17:0] mk(input logic pcw, input logic br, input logic brne,
                                     input logic irw, input logic mw, input logic rw,
                                     input logic iord, input logic asa, input logic [1:0] asb,
                                     input logic zx, input logic [1:0] pcs, input logic m2r,
                                     input logic rd, input logic [1:0] aop, input logic ill);
    return {pcw, br, brne, irw, mw, rw, iord, asa, asb, zx, pcs, m2r, rd, aop, ill};
  endfunction

  localparam logic [17:0] C_F0   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_F1   = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_DEC  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_MADR = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_MRD  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_MWB  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,1'b1,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_MWR  = mk(1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_RTEX = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b00,1'b0,1'b0,2'b10,1'b0);
  localparam logic [17:0] C_RTWB = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b1,2'b00,1'b0);
  localparam logic [17:0] C_BEQ  = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,1'b0,1'b0,2'b01,1'b0);
  localparam logic [17:0] C_BNE  = mk(1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,2'b01,1'b0,1'b0,2'b01,1'b0);
  localparam logic [17:0] C_ADDI = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_ORI  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b1,2'b00,1'b0,1'b0,2'b11,1'b0);
  localparam logic [17:0] C_IWB  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_JEX  = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b10,1'b0,1'b0,2'b00,1'b0);
  localparam logic [17:0] C_TRAP = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1);

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RT   = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  typedef struct packed {
    logic        id;
    logic [3:0]  st;
    logic [17:0] ctl;
  } exp_t;

  exp_t q[$];
  int   tests  = 0;
  int   failed = 0;

  logic [17:0] ctl_a;
  logic [17:0] ctl_b;
  assign ctl_a = {ifa.pcwrite, ifa.branch, ifa.branchne, ifa.irwrite, ifa.memwrite, ifa.regwrite,
                  ifa.iord, ifa.alusrca, ifa.alusrcb, ifa.zeroext, ifa.pcsrc, ifa.memtoreg,
                  ifa.regdst, ifa.aluop, ifa.illegal};
  assign ctl_b = {ifb.pcwrite, ifb.branch, ifb.branchne, ifb.irwrite, ifb.memwrite, ifb.regwrite,
                  ifb.iord, ifb.alusrca, ifb.alusrcb, ifb.zeroext, ifb.pcsrc, ifb.memtoreg,
                  ifb.regdst, ifb.aluop, ifb.illegal};

  // Monitor: every mid-cycle, pop one expected entry and compare the addressed instance.
  exp_t        m_e;
  logic [3:0]  m_st;
  logic [17:0] m_ctl;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      m_e   = q.pop_front();
      m_st  = m_e.id ? ifb.state_dbg : ifa.state_dbg;
      m_ctl = m_e.id ? ctl_b : ctl_a;
      tests = tests + 1;
      if ({m_st, m_ctl} !== {m_e.st, m_e.ctl}) begin
        failed = failed + 1;
        $display("FAIL step%0d dut%0d: got state %0d ctl %b, expected state %0d ctl %b",
                 tests, m_e.id, m_st, m_ctl, m_e.st, m_e.ctl);
      end
    end
  end

  // One clock cycle: drive inputs, optionally queue the expected state/controls for it.
  task automatic cyc(input logic id, input logic rst, input logic [5:0] o, input logic mr,
                     input logic chk, input logic [3:0] st, input logic [17:0] c);
    exp_t e;
    if (id) begin
      ifb.op = o; ifb.mem_ready = mr; rst_b = rst;
    end else begin
      ifa.op = o; ifa.mem_ready = mr; rst_a = rst;
    end
    if (chk) begin
      e.id = id; e.st = st; e.ctl = c;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.op = OP_RT; ifa.mem_ready = 1'b1;
    ifb.op = OP_RT; ifb.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset state, then LW with one MEMRD wait
    cyc(1'b0, 1'b1, OP_LW, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_LW, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_LW, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_LW, 1'b1, 1'b1, 4'd2, C_MADR);
    cyc(1'b0, 1'b0, OP_LW, 1'b0, 1'b1, 4'd3, C_MRD);
    cyc(1'b0, 1'b0, OP_LW, 1'b1, 1'b1, 4'd3, C_MRD);
    cyc(1'b0, 1'b0, OP_LW, 1'b1, 1'b1, 4'd4, C_MWB);
    // SW with two wait cycles in MEMWR
    cyc(1'b0, 1'b0, OP_SW, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_SW, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_SW, 1'b1, 1'b1, 4'd2, C_MADR);
    cyc(1'b0, 1'b0, OP_SW, 1'b0, 1'b1, 4'd5, C_MWR);
    cyc(1'b0, 1'b0, OP_SW, 1'b0, 1'b1, 4'd5, C_MWR);
    cyc(1'b0, 1'b0, OP_SW, 1'b1, 1'b1, 4'd5, C_MWR);
    // FETCH stalled three cycles, then R-type
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, OP_RT, 1'b0, 1'b1, 4'd0, C_F0);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd6, C_RTEX);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd7, C_RTWB);
    // BNE, ORI, BEQ, ADDI, J
    cyc(1'b0, 1'b0, OP_BNE, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_BNE, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_BNE, 1'b1, 1'b1, 4'd12, C_BNE);
    cyc(1'b0, 1'b0, OP_ORI, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_ORI, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_ORI, 1'b1, 1'b1, 4'd13, C_ORI);
    cyc(1'b0, 1'b0, OP_ORI, 1'b1, 1'b1, 4'd10, C_IWB);
    cyc(1'b0, 1'b0, OP_BEQ, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_BEQ, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_BEQ, 1'b1, 1'b1, 4'd8, C_BEQ);
    cyc(1'b0, 1'b0, OP_ADDI, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_ADDI, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_ADDI, 1'b1, 1'b1, 4'd9, C_ADDI);
    cyc(1'b0, 1'b0, OP_ADDI, 1'b1, 1'b1, 4'd10, C_IWB);
    cyc(1'b0, 1'b0, OP_J, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_J, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b0, OP_J, 1'b1, 1'b1, 4'd11, C_JEX);
    // Illegal opcode: sticky trap, cleared only by reset
    cyc(1'b0, 1'b0, OP_BAD, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_BAD, 1'b1, 1'b1, 4'd1, C_DEC);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, OP_BAD, i[0], 1'b1, 4'd14, C_TRAP);
    cyc(1'b0, 1'b1, OP_BAD, 1'b1, 1'b1, 4'd14, C_TRAP);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd0, C_F1);
    // Reset asserted in RTEX: straight back to FETCH, no RTWB write
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd1, C_DEC);
    cyc(1'b0, 1'b1, OP_RT, 1'b1, 1'b1, 4'd6, C_RTEX);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd0, C_F1);
    cyc(1'b0, 1'b0, OP_RT, 1'b1, 1'b1, 4'd1, C_DEC);

    // EXT_OPS=0, MEM_WAIT=0: mem_ready ignored, BNE/ORI trap
    cyc(1'b1, 1'b1, OP_BNE, 1'b0, 1'b1, 4'd0, C_F1);
    cyc(1'b1, 1'b0, OP_BNE, 1'b0, 1'b1, 4'd0, C_F1);
    cyc(1'b1, 1'b0, OP_BNE, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc(1'b1, 1'b0, OP_BNE, 1'b0, 1'b1, 4'd14, C_TRAP);
    cyc(1'b1, 1'b1, OP_ORI, 1'b0, 1'b1, 4'd14, C_TRAP);
    cyc(1'b1, 1'b0, OP_ORI, 1'b0, 1'b1, 4'd0, C_F1);
    cyc(1'b1, 1'b0, OP_ORI, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc(1'b1, 1'b0, OP_ORI, 1'b0, 1'b1, 4'd14, C_TRAP);
    cyc(1'b1, 1'b1, OP_LW, 1'b0, 1'b1, 4'd14, C_TRAP);
    cyc(1'b1, 1'b0, OP_LW, 1'b0, 1'b1, 4'd0, C_F1);
    cyc(1'b1, 1'b0, OP_LW, 1'b0, 1'b1, 4'd1, C_DEC);
    cyc(1'b1, 1'b0, OP_LW, 1'b0, 1'b1, 4'd2, C_MADR);
    cyc(1'b1, 1'b0, OP_LW, 1'b0, 1'b1, 4'd3, C_MRD);
    cyc(1'b1, 1'b0, OP_LW, 1'b0, 1'b1, 4'd4, C_MWB);
    cyc(1'b1, 1'b0, OP_LW, 1'b0, 1'b1, 4'd0, C_F0 | C_F1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #1;
    if (q.size() > 0) begin
      failed = failed + 1;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
